gate_exerciser: RTL and testbench

Self-contained stimulus/checker for 2-input basic-gate modules. It drives the gate's a/b inputs through all four combinations, samples the gate's y output, and compares each sample against a golden truth table selected by gate_sel. It reports per-vector failures and an overall pass flag. It sits on the bench/board side of any gate in the basic_gates library and is the driving end of the a/b -> y interface.

---
 rtl/gate_exerciser.sv | 123 ++++++++++++
 tb/tb_gate_exerciser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_exerciser.sv
// Drives a 2-input gate through {a,b}=00,01,10,11 and checks y_in against the gate_sel truth table.
// Latency: 4*(SETTLE+1) cycles from start edge to done; no backpressure, start is ignored unless idle.
module gate_exerciser #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       a,
    output logic       b,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fv_q, fv_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       pass_q, pass_d;
    logic       expected;

    always_comb begin
        expected = a_q;
        case (sel_q)
            3'd0:    expected = a_q & b_q;
            3'd1:    expected = a_q | b_q;
            3'd2:    expected = a_q ^ b_q;
            3'd3:    expected = ~(a_q & b_q);
            3'd4:    expected = ~(a_q | b_q);
            3'd5:    expected = ~(a_q ^ b_q);
            3'd6:    expected = ~a_q;
            default: expected = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fv_d    = fv_q;
        a_d     = a_q;
        b_d     = b_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = gate_sel;
                    idx_d   = 2'd0;
                    fv_d    = 4'd0;
                    pass_d  = 1'b0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) state_d = SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SAMPLE: begin
                if (y_in != expected) fv_d[idx_q] = 1'b1;
                if (idx_q == 2'd3) begin
                    // pass must include the result of this final sample
                    pass_d  = (fv_d == 4'd0);
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    cnt_d   = CNT_INIT;
                    state_d = DRIVE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            fv_q    <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign fail_vec = fv_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: SETTLE=1 and SETTLE=4 instances, each driving a modelled gate.
module tb_gate_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start4;
    logic [2:0] sel1, sel4;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic       a4, b4, y4, busy4, done4, pass4;
    logic [3:0] fv1, fv4;

    // gate model per instance: which function it implements and whether it is stuck
    logic [2:0] gsel_m [2];
    int         ymode_m [2];

    function automatic logic ymodel(input logic [2:0] g, input int m, input logic ai, input logic bi);
        logic [3:0] tt;
        case (g)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        if (m == 1) return 1'b0;
        if (m == 2) return 1'b1;
        return tt[{ai, bi}];
    endfunction

    assign y1 = ymodel(gsel_m[0], ymode_m[0], a1, b1);
    assign y4 = ymodel(gsel_m[1], ymode_m[1], a4, b4);

    gate_exerciser #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(sel1),
        .a(a1), .b(b1), .y_in(y1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_vec(fv1)
    );

    gate_exerciser #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .gate_sel(sel4),
        .a(a4), .b(b4), .y_in(y4), .busy(busy4), .done(done4),
        .pass(pass4), .fail_vec(fv4)
    );

    typedef struct {
        logic [3:0] fv;
        logic       pass;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        int         ymode;
        logic [3:0] fv;
        logic       pass;
    } vec_t;

    exp_t sb[$];
    vec_t tbl [8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic drive_start(input int inst, input logic v);
        if (inst == 0) start1 = v;
        else           start4 = v;
    endtask

    task automatic drive_sel(input int inst, input logic [2:0] s);
        if (inst == 0) sel1 = s;
        else           sel4 = s;
    endtask

    task automatic obs(input int inst, output logic ao, output logic bo, output logic bz,
                       output logic dn, output logic po, output logic [3:0] fvo);
        if (inst == 0) begin
            ao = a1; bo = b1; bz = busy1; dn = done1; po = pass1; fvo = fv1;
        end else begin
            ao = a4; bo = b4; bz = busy4; dn = done4; po = pass4; fvo = fv4;
        end
    endtask

    task automatic launch(input int inst, input logic [2:0] sel, input int ymode,
                          input logic [3:0] fv, input logic pass);
        exp_t e;
        gsel_m[inst]  = sel;
        ymode_m[inst] = ymode;
        drive_sel(inst, sel);
        drive_start(inst, 1'b1);
        e.fv   = fv;
        e.pass = pass;
        sb.push_back(e);
    endtask

    // Called at the negedge of the first cycle after the start edge.
    task automatic track(input int inst, input int settle, input bit misuse, input string name);
        int         c = 1;
        int         vi;
        int         ab_err = 0;
        bit         seen = 0;
        int         limit = 4 * (settle + 1) + 6;
        logic       ao, bo, bz, dn, po;
        logic [3:0] fvo;
        exp_t       e;
        while (c <= limit && !seen) begin
            obs(inst, ao, bo, bz, dn, po, fvo);
            if (dn) begin
                seen = 1;
            end else begin
                vi = (c - 1) / (settle + 1);
                if (c > 4 * (settle + 1) || {ao, bo} != 2'(vi) || !bz) ab_err++;
                if (misuse && c == 3) begin
                    drive_start(inst, 1'b1);
                    drive_sel(inst, 3'd7);
                end else if (misuse && c == 4) begin
                    drive_start(inst, 1'b0);
                end
                @(negedge clk);
                c++;
            end
        end
        chk({name, "_ab_seq"}, ab_err, 0);
        chk({name, "_latency"}, c - 1, 4 * (settle + 1));
        chk({name, "_busy_at_done"}, {bz, ao, bo}, 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_fail_vec"}, fvo, e.fv);
            chk({name, "_pass"}, po, e.pass);
        end else begin
            chk({name, "_sb_entry"}, sb.size(), 1);
        end
    endtask

    task automatic run_one(input int inst, input logic [2:0] sel, input int ymode,
                           input logic [3:0] fv, input logic pass, input int settle,
                           input bit misuse, input string name);
        @(negedge clk);
        launch(inst, sel, ymode, fv, pass);
        @(negedge clk);
        drive_start(inst, 1'b0);
        track(inst, settle, misuse, name);
    endtask

    task automatic idle_check(input int n, input string name);
        logic       ao, bo, bz, dn, po;
        logic [3:0] fvo;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs(0, ao, bo, bz, dn, po, fvo);
            chk(name, {bz, dn, ao, bo}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got unfinished run, required completion");
        $fatal(1);
    end

    initial begin
        logic       ao, bo, bz, dn, po;
        logic [3:0] fvo;

        rst_n = 1'b0;
        start1 = 1'b0; start4 = 1'b0;
        sel1 = 3'd0;   sel4 = 3'd0;
        gsel_m[0] = 3'd0; gsel_m[1] = 3'd0;
        ymode_m[0] = 0;   ymode_m[1] = 0;

        // sel, ymode (0 correct, 1 stuck-0, 2 stuck-1), fail_vec, pass
        tbl[0] = '{3'd0, 0, 4'b0000, 1'b1};
        tbl[1] = '{3'd1, 1, 4'b1110, 1'b0};
        tbl[2] = '{3'd3, 2, 4'b1000, 1'b0};
        tbl[3] = '{3'd2, 0, 4'b0000, 1'b1};
        tbl[4] = '{3'd5, 1, 4'b1001, 1'b0};
        tbl[5] = '{3'd6, 0, 4'b0000, 1'b1};
        tbl[6] = '{3'd4, 2, 4'b1110, 1'b0};
        tbl[7] = '{3'd7, 1, 4'b1100, 1'b0};

        #2;
        chk("reset_dut1", {a1, b1, busy1, done1, pass1, fv1}, 0);
        chk("reset_dut4", {a4, b4, busy4, done4, pass4, fv4}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(20, "idle_after_reset");

        for (int i = 0; i < 8; i++)
            run_one(0, tbl[i].sel, tbl[i].ymode, tbl[i].fv, tbl[i].pass, 1, 1'b0,
                    $sformatf("tbl%0d", i));

        run_one(1, 3'd2, 0, 4'b0000, 1'b1, 4, 1'b0, "settle4_xor");

        // restart attempt and gate_sel change mid-run against an AND gate
        run_one(0, 3'd0, 0, 4'b0000, 1'b1, 1, 1'b1, "misuse");
        drive_sel(0, 3'd0);

        // start held high across two runs
        @(negedge clk);
        launch(0, 3'd1, 0, 4'b0000, 1'b1);
        @(negedge clk);
        track(0, 1, 1'b0, "b2b_first");
        @(negedge clk);
        obs(0, ao, bo, bz, dn, po, fvo);
        chk("b2b_gap_idle", {bz, dn}, 0);
        launch(0, 3'd1, 0, 4'b0000, 1'b1);
        @(negedge clk);
        obs(0, ao, bo, bz, dn, po, fvo);
        chk("b2b_second_busy", bz, 1);
        drive_start(0, 1'b0);
        track(0, 1, 1'b0, "b2b_second");

        // abort during SAMPLE of vector 2 with an OR gate stuck at 0
        @(negedge clk);
        gsel_m[0] = 3'd1; ymode_m[0] = 1; sel1 = 3'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        obs(0, ao, bo, bz, dn, po, fvo);
        chk("pre_abort_fail_vec", fvo, 4'b0010);
        chk("pre_abort_vector", {bz, ao, bo}, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        obs(0, ao, bo, bz, dn, po, fvo);
        chk("abort_outputs", {ao, bo, bz, dn, po, fvo}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(12, "no_done_after_abort");
        run_one(0, 3'd0, 0, 4'b0000, 1'b1, 1, 1'b0, "clean_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
